// File: rtl/uart_alu_interface.sv
// Command sequencer between the UART receiver, the ALU and the UART transmitter.
// It collects operand A, operand B and an opcode byte, drives the ALU, then
// sends the ALU result back as a single byte.
//
// state   | meaning
// --------+---------------------------------------------------------------
// WAIT_A  | idle, next received byte is operand A
// WAIT_B  | operand A held, next received byte is operand B
// WAIT_OP | both operands held, next received byte is the opcode
// EXEC    | opcode accepted, capture the ALU result
// SEND    | raise tx_start for one cycle
// WAIT_TX | byte handed to the transmitter, wait for tx_done
module uart_alu_interface #(
    parameter int N    = 8,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    rx_data,
    input  logic            rx_valid,
    input  logic [N-1:0]    alu_result,
    input  logic            tx_done,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [OP_W-1:0] alu_op,
    output logic [N-1:0]    tx_data,
    output logic            tx_start,
    output logic            busy,
    output logic            op_error,
    output logic            overrun
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t          state_q, state_d;
    logic            rx_valid_q, rx_valid_d;
    logic [N-1:0]    alu_a_q, alu_a_d;
    logic [N-1:0]    alu_b_q, alu_b_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic [N-1:0]    tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    logic            op_error_q, op_error_d;
    logic            overrun_q, overrun_d;

    logic            acc;
    logic            op_legal;

    // A held rx_valid level counts as a single byte: accept on its rising edge only.
    assign acc = rx_valid & ~rx_valid_q;

    // Opcode whitelist; upper bits above the opcode field must be zero.
    always_comb begin
        op_legal = 1'b0;
        if (rx_data[N-1:OP_W] == '0) begin
            case (rx_data[OP_W-1:0])
                6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b100110, 6'b100111, 6'b000011, 6'b000010: op_legal = 1'b1;
                default: op_legal = 1'b0;
            endcase
        end
    end

    // Next-state and registered-output logic for the command sequencer.
    always_comb begin
        state_d    = state_q;
        rx_valid_d = rx_valid;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        op_error_d = 1'b0;
        overrun_d  = 1'b0;

        case (state_q)
            WAIT_A: begin
                if (acc) begin
                    alu_a_d = rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (acc) begin
                    alu_b_d = rx_data;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (acc) begin
                    if (op_legal) begin
                        alu_op_d = rx_data[OP_W-1:0];
                        busy_d   = 1'b1;
                        state_d  = EXEC;
                    end else begin
                        // Operands are discarded; the next byte starts a new command.
                        op_error_d = 1'b1;
                        state_d    = WAIT_A;
                    end
                end
            end
            EXEC: begin
                overrun_d = acc;
                tx_data_d = alu_result;
                state_d   = SEND;
            end
            SEND: begin
                overrun_d  = acc;
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                // A byte coinciding with tx_done is still dropped, not taken as A.
                overrun_d = acc;
                if (tx_done) begin
                    busy_d  = 1'b0;
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= WAIT_A;
            rx_valid_q <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            op_error_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= rx_valid_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            op_error_q <= op_error_d;
            overrun_q  <= overrun_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign op_error = op_error_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: a vector table of command triples
// plus hand-written sequences for held rx_valid, overrun and mid-command reset.
module tb_uart_alu_interface;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       op_error;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        logic       legal;
    } vec_t;

    vec_t vecs[10];

    uart_alu_interface #(.N(8), .OP_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .alu_result (alu_result),
        .tx_done    (tx_done),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .op_error   (op_error),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Combinational ALU stand-in driven by the DUT's registered operands.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h26:   alu_result = alu_a ^ alu_b;
            6'h27:   alu_result = ~(alu_a | alu_b);
            6'h03:   alu_result = 8'($signed(alu_a) >>> alu_b);
            6'h02:   alu_result = alu_a >> alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one byte for a single cycle; returns at the negedge after it was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Called right after the opcode edge E; checks tx_start lands only after E+2.
    task automatic finish_cmd(input string name, input logic [7:0] exp_op, input logic [7:0] exp_res);
        int pulses = 0;
        int first_k = 0;
        check({name, " busy"}, 8'(busy), 8'h01);
        check({name, " alu_op"}, 8'(alu_op), exp_op);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (tx_start) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        check({name, " tx_start count"}, 8'(pulses), 8'h01);
        check({name, " tx_start latency"}, 8'(first_k), 8'h02);
        check({name, " tx_data"}, tx_data, exp_res);
        check({name, " busy hold"}, 8'(busy), 8'h01);
    endtask

    task automatic tx_done_pulse(input string name);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({name, " busy clear"}, 8'(busy), 8'h00);
    endtask

    initial begin
        logic [7:0] exp_op;
        int         starts;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b1};
        vecs[1] = '{8'hF0, 8'h0F, 8'h27, 8'h00, 1'b1};
        vecs[2] = '{8'h80, 8'h02, 8'h03, 8'hE0, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 8'h21, 8'h00, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 8'h60, 8'h00, 1'b0};
        vecs[5] = '{8'h01, 8'h01, 8'h22, 8'h00, 1'b1};
        vecs[6] = '{8'hAA, 8'h0F, 8'h24, 8'h0A, 1'b1};
        vecs[7] = '{8'hAA, 8'h0F, 8'h25, 8'hAF, 1'b1};
        vecs[8] = '{8'hAA, 8'h0F, 8'h26, 8'hA5, 1'b1};
        vecs[9] = '{8'h80, 8'h03, 8'h02, 8'h10, 1'b1};

        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset alu_a", alu_a, 8'h00);
        check("reset alu_b", alu_b, 8'h00);
        check("reset alu_op", 8'(alu_op), 8'h00);
        check("reset tx_data", tx_data, 8'h00);
        check("reset flags", {4'b0, tx_start, busy, op_error, overrun}, 8'h00);

        exp_op = 8'h00;
        for (int i = 0; i < 10; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            send_byte(vecs[i].a);
            send_byte(vecs[i].b);
            send_byte(vecs[i].op);
            check({nm, " alu_a"}, alu_a, vecs[i].a);
            check({nm, " alu_b"}, alu_b, vecs[i].b);
            if (vecs[i].legal) begin
                exp_op = vecs[i].op;
                check({nm, " op_error"}, 8'(op_error), 8'h00);
                finish_cmd(nm, exp_op, vecs[i].res);
                tx_done_pulse(nm);
            end else begin
                check({nm, " op_error"}, 8'(op_error), 8'h01);
                check({nm, " busy"}, 8'(busy), 8'h00);
                check({nm, " alu_op kept"}, 8'(alu_op), exp_op);
                @(negedge clk);
                check({nm, " op_error pulse"}, 8'(op_error), 8'h00);
                starts = 0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (tx_start) starts++;
                end
                check({nm, " no tx_start"}, 8'(starts), 8'h00);
            end
        end

        // Held rx_valid: one byte only, then the machine expects B.
        @(negedge clk);
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        repeat (20) @(negedge clk);
        rx_valid = 1'b0;
        check("hold alu_a", alu_a, 8'h11);
        check("hold alu_b kept", alu_b, 8'h03);
        send_byte(8'h02);
        check("hold next is B", alu_b, 8'h02);
        send_byte(8'h20);
        finish_cmd("hold", 8'h20, 8'h13);

        // Extra byte while waiting for the transmitter.
        send_byte(8'h55);
        check("ovr pulse", 8'(overrun), 8'h01);
        check("ovr alu_a kept", alu_a, 8'h11);
        @(negedge clk);
        check("ovr one cycle", 8'(overrun), 8'h00);
        tx_done_pulse("ovr");
        send_byte(8'h09);
        check("ovr next A", alu_a, 8'h09);
        send_byte(8'h04);
        send_byte(8'h22);
        finish_cmd("sub", 8'h22, 8'h05);

        // Byte arriving on the same edge as tx_done is dropped.
        @(negedge clk);
        rx_data  = 8'h66;
        rx_valid = 1'b1;
        tx_done  = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        check("same-edge overrun", 8'(overrun), 8'h01);
        check("same-edge busy", 8'(busy), 8'h00);
        check("same-edge alu_a", alu_a, 8'h09);
        send_byte(8'h33);
        check("same-edge next A", alu_a, 8'h33);
        send_byte(8'h01);
        send_byte(8'h20);
        finish_cmd("same-edge cmd", 8'h20, 8'h34);
        tx_done_pulse("same-edge cmd");

        // Reset pulse while in SEND suppresses tx_start.
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h20);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst-send tx_start", 8'(tx_start), 8'h00);
        check("rst-send flags", {4'b0, tx_start, busy, op_error, overrun}, 8'h00);
        check("rst-send operands", alu_a | alu_b | 8'(alu_op) | tx_data, 8'h00);
        starts = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        check("rst-send no late tx_start", 8'(starts), 8'h00);
        send_byte(8'h04);
        send_byte(8'h02);
        send_byte(8'h22);
        check("rst-send alu_a", alu_a, 8'h04);
        finish_cmd("rst-send cmd", 8'h22, 8'h02);
        tx_done_pulse("rst-send cmd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Command sequencer that sits directly downstream of the UART receiver and in front of the transmitter and the combinational ALU. It collects three received bytes (operand A, operand B, opcode), validates the opcode, and drives the ALU inputs. It then captures the ALU result and hands it to the UART transmitter as a single byte with a start/done handshake.

## Interface
- N, 8, data/operand width; equals receiver data width
- OP_W, 6, opcode width; taken from rx_data[OP_W-1:0]
- clk  input  1  system clock; the only clock
- reset  input  1  synchronous, active-low reset; sampled on rising clk edge, reset=0 resets
- rx_data  input  N  received byte; valid while rx_valid=1
- rx_valid  input  1  receiver valid; may be a pulse or a held level; one byte per rising edge
- alu_result  input  N  combinational ALU output for current alu_a/alu_b/alu_op
- tx_done  input  1  one-cycle pulse from transmitter when a byte has fully left
- alu_a  output  N  registered operand A
- alu_b  output  N  registered operand B
- alu_op  output  OP_W  registered opcode
- tx_data  output  N  registered result byte for transmitter
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data
- busy  output  1  high from opcode acceptance until tx_done
- op_error  output  1  one-cycle pulse: opcode byte rejected
- overrun  output  1  one-cycle pulse: byte arrived while busy and was dropped

## Operation
- Byte strobe: acc = rx_valid & ~rx_valid_q (rx_valid_q a registered copy, reset 0). A held rx_valid counts once.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. Reset state WAIT_A.
- WAIT_A: on acc, alu_a <= rx_data, -> WAIT_B.
- WAIT_B: on acc, alu_b <= rx_data, -> WAIT_OP.
- WAIT_OP: on acc, check opcode:
  - Legal iff rx_data[N-1:OP_W]==0 and rx_data[OP_W-1:0] is one of: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL.
  - Legal: alu_op <= rx_data[OP_W-1:0], busy <= 1, -> EXEC.
  - Illegal: op_error pulse, alu_op unchanged, -> WAIT_A. Operands are discarded; the next byte is a new A.
- EXEC: tx_data <= alu_result, -> SEND.
- SEND: tx_start <= 1 for exactly one cycle, -> WAIT_TX.
- WAIT_TX: on tx_done, busy <= 0, -> WAIT_A.
  - tx_done in any other state is ignored.
- acc in EXEC/SEND/WAIT_TX: byte dropped, overrun pulse, no state change.
- No arithmetic in block; result is N bits as supplied; no width extension.
- alu_a/alu_b/alu_op hold their values after a command until overwritten.

## Timing
- Reset values: alu_a=0, alu_b=0, alu_op=0, tx_data=0, tx_start=0, busy=0, op_error=0, overrun=0, state WAIT_A.
- Reset mid-operation (any state) returns everything to reset values at the next edge; a pending tx_start is not issued.
- Opcode accepted at edge E:
  - alu_op and busy valid after E.
  - tx_data captured at E+1.
  - tx_start high between E+2 and E+3.
- Minimum opcode-to-tx_start latency is 2 cycles.
- tx_done at the same edge as acc in WAIT_TX: state returns to WAIT_A; that byte is dropped and flagged overrun (it is not taken as A).
- op_error and overrun are each high for one cycle, never held.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then bytes 0x05, 0x03, 0x20 (ADD) with alu_result model a+b -> alu_a=0x05, alu_b=0x03, alu_op=0x20; tx_data=0x08; single tx_start pulse 2 cycles after the opcode edge; busy high until tx_done.
- Bytes 0xF0, 0x0F, 0x27 (NOR) -> tx_data=0x00, one tx_start; then 0x80, 0x02, 0x03 (SRA) -> tx_data=0xE0.
- Opcode 0x21, then separately 0x60 -> op_error pulse for each, no tx_start, state WAIT_A; next triple 0x01, 0x01, 0x22 -> tx_data=0x00.
- rx_valid held high 20 cycles with 0x11 -> only one byte accepted (alu_a=0x11, state WAIT_B).
- Extra byte during WAIT_TX -> overrun pulse, alu_a unchanged; after tx_done the next byte loads alu_a.
- reset=0 asserted for one cycle in SEND -> no tx_start, all outputs 0 on the next cycle, the following triple processed normally.
